kulisch_acc_normalize: RTL
==========================

KULISCH_ACC_NORMALIZE -- requirements
Module: kulisch_acc_normalize

Interface
REQ-001 SHALL have parameter ACC_WIDTH, default 32: Kulisch accumulator width; equals upstream multiply-add accumulator width.
REQ-002 SHALL have parameter EXP_OUT, default 5: output float exponent width.
REQ-003 SHALL have parameter FRAC_OUT, default 10: output float fraction width.
REQ-004 SHALL have parameter EXP_OFFSET, default 5 (signed int): output biased exponent minus accumulator leading-one bit index.
REQ-005 SHALL have port clock  in  1  sole clock, rising edge.
REQ-006 SHALL have port resetn  in  1  asynchronous active-low reset.
REQ-007 SHALL have port in_valid  in  1  upstream term valid.
REQ-008 SHALL have port in_ready  out  1  beat accepted when in_valid && in_ready.
REQ-009 SHALL have port in_first  in  1  beat starts a new dot product.
REQ-010 SHALL have port in_last  in  1  beat ends the dot product.
REQ-011 SHALL have port acc_feedback  out  ACC_WIDTH  drives upstream accIn.
REQ-012 SHALL have port acc_next  in  ACC_WIDTH  upstream accOut (two's complement).
REQ-013 SHALL have port out_valid  out  1  result valid.
REQ-014 SHALL have port out_ready  in  1  result consumed when out_valid && out_ready.
REQ-015 SHALL have port out_data  out  1+EXP_OUT+FRAC_OUT  {sign, biased exp, frac}.
REQ-016 SHALL have port out_ovf  out  1  sticky accumulator-overflow flag for this result.

Function
REQ-017 SHALL implement FSM states ACC, ABS, NORM, RND, OUT; in_ready = (state==ACC); out_valid = (state==OUT).
REQ-018 SHALL drive acc_feedback = in_first ? 0 : acc_q, combinationally.
REQ-019 On accepted beat SHALL load acc_q <= acc_next; with in_last set SHALL go ACC->ABS; in_first and in_last in the same beat are legal.
REQ-020 ABS: sign <= acc_q MSB; magnitude <= |acc_q| (ACC_WIDTH+1 bits, so -2^(ACC_WIDTH-1) is exact); next NORM.
REQ-021 NORM: leading-one index p located; magnitude left-normalized; next RND.
REQ-022 RND: biased exponent e = p + EXP_OFFSET; FRAC_OUT bits below leading one; round-to-nearest-even on guard + sticky; mantissa carry-out increments e; next OUT.
REQ-023 Zero magnitude SHALL produce out_data all zeros (sign 0).
REQ-024 e <= 0 after rounding SHALL flush to signed zero (sign kept, exp 0, frac 0).
REQ-025 e >= 2^EXP_OUT-1 after rounding SHALL saturate: exp = 2^EXP_OUT-2, frac all ones, sign kept.
REQ-026 out_valid SHALL rise exactly 4 clock edges after the edge accepting the last beat, i.e. after ABS, NORM and RND cycles plus the edge entering OUT; out_data and out_ovf stable while out_valid && !out_ready.
REQ-027 On OUT handshake SHALL go to ACC, clear acc_q to 0 and clear out_ovf.
REQ-028 in_valid outside ACC SHALL be ignored; a beat without in_first accumulates onto acc_q.

Reset
REQ-029 resetn low SHALL asynchronously force state ACC, acc_q 0, out_valid 0, out_data 0, out_ovf 0, in_ready 1 after release, including mid-ABS/NORM/RND/OUT.

Configuration
REQ-030 Macro KULISCH_OVF_DETECT_EN defined: per beat, term = acc_next - acc_feedback; overflow when acc_feedback and term have equal signs and acc_next sign differs; sticky flag; if set at conversion, out_data SHALL be saturated per REQ-025 with the sign of acc_feedback at first overflow.
REQ-031 Macro undefined: no detection logic, out_ovf tied 0, accumulator wraps silently.

Structure
REQ-032 Package kulisch_pkg SHALL hold the FSM state enum and the float field width/localparam helpers.
REQ-033 Sub-module kulisch_lzc (parameterized leading-one detector returning p and a zero flag) SHALL be used by NORM.

Verification (ACC_WIDTH=32, EXP_OUT=5, FRAC_OUT=10, EXP_OFFSET=5)
REQ-034 Single beat first+last, acc_next=0x00000400 -> out_data=0x3C00 4 edges later; acc_feedback=0 during beat.
REQ-035 Terms 0x400, 0x800, -0x800 (bench models upstream adder) -> acc_feedback 0, 0x400, 0xC00 per beat; result 0x3C00; final 0xFFFFFC00 alone -> 0xBC00.
REQ-036 Ties: acc 0x00000801 -> 0x4000; acc 0x00000803 -> 0x4002; acc 0 -> 0x0000.
REQ-037 acc 0x40000000 -> 0x7BFF; terms 0x70000000 twice: with macro out_ovf=1, out_data=0x7BFF; without macro out_ovf=0, out_data=0xFBFF.
REQ-038 out_ready low 5 cycles -> out_data held, in_ready=0; resetn pulsed during NORM -> out_valid 0, acc_feedback 0, next single-beat 0x400 -> 0x3C00.

Source files
------------

// File: rtl/kulisch_pkg.sv
// kulisch_pkg -- shared definitions for the Kulisch accumulator normalizer.
//   state_e        : conversion FSM states (ACC, ABS, NORM, RND, OUT)
//   float_width()  : total packed float width {sign, exp, frac}
//   exp_all_ones() : reserved all-ones biased exponent (overflow threshold)
//   exp_sat()      : largest finite biased exponent used for saturation
package kulisch_pkg;

  typedef enum logic [2:0] {
    ST_ACC,
    ST_ABS,
    ST_NORM,
    ST_RND,
    ST_OUT
  } state_e;

  function automatic int unsigned float_width(int unsigned exp_w, int unsigned frac_w);
    return 1 + exp_w + frac_w;
  endfunction

  function automatic int exp_all_ones(int unsigned exp_w);
    return (1 << exp_w) - 1;
  endfunction

  function automatic int exp_sat(int unsigned exp_w);
    return (1 << exp_w) - 2;
  endfunction

endpackage

// File: rtl/kulisch_lzc.sv
// kulisch_lzc -- leading-one detector.
//   din  : input vector
//   pos  : bit index of the most significant set bit (0 when din is zero)
//   zero : high when din has no set bit
module kulisch_lzc #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned PW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] din,
  output logic [PW-1:0]    pos,
  output logic             zero
);

  // Ascending scan: the last set bit seen is the most significant one.
  always_comb begin
    pos  = '0;
    zero = 1'b1;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (din[i]) begin
        pos  = PW'(i);
        zero = 1'b0;
      end
    end
  end

endmodule

// File: rtl/kulisch_acc_normalize.sv
// kulisch_acc_normalize -- Kulisch accumulator with float conversion.
// Accumulates two's-complement partial sums coming back from an upstream
// multiply-add, then converts the final sum to {sign, biased exp, frac}
// with round-to-nearest-even, flush-to-zero and saturation.
//   clock, resetn          : rising-edge clock, async active-low reset
//   in_valid/in_ready      : term handshake; in_first / in_last frame a dot product
//   acc_feedback           : accumulator value presented to upstream accIn
//   acc_next               : upstream accOut
//   out_valid/out_ready    : result handshake
//   out_data               : {sign, biased exp, frac}
//   out_ovf                : sticky accumulator overflow for this result
// Optional feature macro: KULISCH_OVF_DETECT_EN (signed overflow detection
// with saturated output). Undefined: accumulator wraps, out_ovf tied low.
module kulisch_acc_normalize
  import kulisch_pkg::*;
#(
  parameter int unsigned ACC_WIDTH  = 32,
  parameter int unsigned EXP_OUT    = 5,
  parameter int unsigned FRAC_OUT   = 10,
  parameter int          EXP_OFFSET = 5
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_first,
  input  logic                      in_last,
  output logic [ACC_WIDTH-1:0]      acc_feedback,
  input  logic [ACC_WIDTH-1:0]      acc_next,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [EXP_OUT+FRAC_OUT:0] out_data,
  output logic                      out_ovf
);

  localparam int unsigned MAG_W = ACC_WIDTH + 1;
  localparam int unsigned PW    = $clog2(MAG_W);
  localparam int unsigned OUT_W = float_width(EXP_OUT, FRAC_OUT);
  localparam int          EXP_INF = exp_all_ones(EXP_OUT);
  localparam logic [EXP_OUT-1:0] EXP_SAT_F = EXP_OUT'(exp_sat(EXP_OUT));
  // Guard bit position inside the left-normalized magnitude (leading one at ACC_WIDTH).
  localparam int unsigned G_BIT = ACC_WIDTH - 1 - FRAC_OUT;

  state_e               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 sign_q, sign_d;
  logic [MAG_W-1:0]     mag_q, mag_d;
  logic [MAG_W-1:0]     norm_q, norm_d;
  logic [PW-1:0]        p_q, p_d;
  logic                 zero_q, zero_d;
  logic [OUT_W-1:0]     out_data_q, out_data_d;

  logic [PW-1:0]        lzc_pos;
  logic                 lzc_zero;
  logic [PW-1:0]        shamt;

  logic                 accept;
  logic                 ovf_active;
  logic                 ovf_sign;

  logic [FRAC_OUT-1:0]  frac_raw;
  logic                 guard;
  logic                 sticky;
  logic                 round_up;
  logic [FRAC_OUT:0]    mant;
  int                   e_rnd;

  assign accept = in_valid && (state_q == ST_ACC);

  always_comb begin
    acc_feedback = in_first ? '0 : acc_q;
    in_ready     = (state_q == ST_ACC);
    out_valid    = (state_q == ST_OUT);
    out_data     = out_data_q;
  end

`ifdef KULISCH_OVF_DETECT_EN
  logic                 ovf_q, ovf_d;
  logic                 ovf_sign_q, ovf_sign_d;
  logic [ACC_WIDTH-1:0] term;
  logic                 beat_ovf;

  // Recover the upstream term and flag a same-sign add whose result flips sign.
  always_comb begin
    term       = acc_next - acc_feedback;
    beat_ovf   = (acc_feedback[ACC_WIDTH-1] == term[ACC_WIDTH-1]) &&
                 (acc_next[ACC_WIDTH-1] != acc_feedback[ACC_WIDTH-1]);
    ovf_d      = ovf_q;
    ovf_sign_d = ovf_sign_q;
    if (accept && beat_ovf && !ovf_q) begin
      ovf_d      = 1'b1;
      ovf_sign_d = acc_feedback[ACC_WIDTH-1];
    end
    if (state_q == ST_OUT && out_ready) begin
      ovf_d      = 1'b0;
      ovf_sign_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ovf_q      <= 1'b0;
      ovf_sign_q <= 1'b0;
    end else begin
      ovf_q      <= ovf_d;
      ovf_sign_q <= ovf_sign_d;
    end
  end

  assign ovf_active = ovf_q;
  assign ovf_sign   = ovf_sign_q;
  assign out_ovf    = ovf_q;
`else
  assign ovf_active = 1'b0;
  assign ovf_sign   = 1'b0;
  assign out_ovf    = 1'b0;
`endif

  kulisch_lzc #(
    .WIDTH (MAG_W),
    .PW    (PW)
  ) u_lzc (
    .din  (mag_q),
    .pos  (lzc_pos),
    .zero (lzc_zero)
  );

  assign shamt = PW'(ACC_WIDTH) - lzc_pos;

  // Rounding datapath on the registered normalized magnitude.
  always_comb begin
    frac_raw = norm_q[ACC_WIDTH-1 -: FRAC_OUT];
    guard    = norm_q[G_BIT];
    sticky   = |norm_q[G_BIT-1:0];
    round_up = guard & (sticky | frac_raw[0]);
    mant     = {1'b0, frac_raw} + {{FRAC_OUT{1'b0}}, round_up};
    e_rnd    = int'(p_q) + EXP_OFFSET + int'(mant[FRAC_OUT]);
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    sign_d     = sign_q;
    mag_d      = mag_q;
    norm_d     = norm_q;
    p_d        = p_q;
    zero_d     = zero_q;
    out_data_d = out_data_q;
    unique case (state_q)
      ST_ACC: begin
        if (accept) begin
          acc_d = acc_next;
          if (in_last) state_d = ST_ABS;
        end
      end
      ST_ABS: begin
        sign_d = acc_q[ACC_WIDTH-1];
        // One extra bit keeps |-2^(ACC_WIDTH-1)| exact.
        if (acc_q[ACC_WIDTH-1])
          mag_d = ~{acc_q[ACC_WIDTH-1], acc_q} + {{ACC_WIDTH{1'b0}}, 1'b1};
        else
          mag_d = {1'b0, acc_q};
        state_d = ST_NORM;
      end
      ST_NORM: begin
        p_d     = lzc_pos;
        zero_d  = lzc_zero;
        norm_d  = mag_q << shamt;
        state_d = ST_RND;
      end
      ST_RND: begin
        if (zero_q)
          out_data_d = '0;
        else if (ovf_active)
          out_data_d = {ovf_sign, EXP_SAT_F, {FRAC_OUT{1'b1}}};
        else if (e_rnd >= EXP_INF)
          out_data_d = {sign_q, EXP_SAT_F, {FRAC_OUT{1'b1}}};
        else if (e_rnd <= 0)
          out_data_d = {sign_q, {EXP_OUT{1'b0}}, {FRAC_OUT{1'b0}}};
        else
          out_data_d = {sign_q, EXP_OUT'(e_rnd), mant[FRAC_OUT-1:0]};
        state_d = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) begin
          acc_d   = '0;
          state_d = ST_ACC;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_ACC;
      acc_q      <= '0;
      sign_q     <= 1'b0;
      mag_q      <= '0;
      norm_q     <= '0;
      p_q        <= '0;
      zero_q     <= 1'b1;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      sign_q     <= sign_d;
      mag_q      <= mag_d;
      norm_q     <= norm_d;
      p_q        <= p_d;
      zero_q     <= zero_d;
      out_data_q <= out_data_d;
    end
  end

endmodule
